// File: rtl/lcd_pkg.sv
// lcd_pkg: shared definitions for the LCD frame sequencer.
//   - lcd_state_t : sequencer state encoding
//   - LCD_CMD_*   : HD44780 init commands
//   - LCD_ADDR_*  : DDRAM set-address commands for the two rows
//   - LCD_COLS    : characters per row
//   - init_cmd()  : init command by position in the power-up sequence
//   - row_char()  : character i of a row, leftmost = index 0
package lcd_pkg;

  typedef enum logic [2:0] {
    PWR_WAIT,
    INIT_CMD,
    CLR_WAIT,
    IDLE,
    ADDR1,
    ROW1,
    ADDR2,
    ROW2
  } lcd_state_t;

  localparam logic [7:0] LCD_CMD_FUNCSET = 8'h38;
  localparam logic [7:0] LCD_CMD_DISPON  = 8'h0C;
  localparam logic [7:0] LCD_CMD_ENTRY   = 8'h06;
  localparam logic [7:0] LCD_CMD_CLEAR   = 8'h01;
  localparam logic [7:0] LCD_ADDR_ROW1   = 8'h80;
  localparam logic [7:0] LCD_ADDR_ROW2   = 8'hC0;

  localparam int LCD_COLS = 16;

  function automatic logic [7:0] init_cmd(input logic [1:0] i);
    logic [7:0] cmd;
    cmd = LCD_CMD_FUNCSET;
    case (i)
      2'd0: cmd = LCD_CMD_FUNCSET;
      2'd1: cmd = LCD_CMD_DISPON;
      2'd2: cmd = LCD_CMD_ENTRY;
      2'd3: cmd = LCD_CMD_CLEAR;
      default: cmd = LCD_CMD_FUNCSET;
    endcase
    return cmd;
  endfunction

  // Leftmost character lives in the top byte, so index 0 maps to [127:120].
  function automatic logic [7:0] row_char(input logic [127:0] row, input logic [3:0] i);
    return row[8*(LCD_COLS-1-int'(i)) +: 8];
  endfunction

endpackage

// File: rtl/lcd_frame_sequencer.sv
// lcd_frame_sequencer: turns 2x16 character frames into an ordered
// HD44780 byte stream (init commands, DDRAM addresses, characters) over a
// valid/ready handshake towards the LCD pin-timing driver.
//
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   frame_req                : one-cycle request to show row1/row2
//   row1, row2 [127:0]       : row text, [127:120] is the leftmost char
//   byte_data [7:0], byte_rs : byte to the driver, rs=1 for characters
//   byte_valid / byte_ready  : handshake, transfer when both high
//   init_done                : level, power-up init complete
//   busy                     : high in every state except IDLE
//   frame_done               : pulse after the last byte of a frame
//   frame_skipped            : pulse when an unchanged frame is dropped
//                              (only with LCD_SEQ_DIFF_EN defined)
//
// Optional feature macro: LCD_SEQ_DIFF_EN (suppress frames identical to the
// last transmitted one).
module lcd_frame_sequencer
  import lcd_pkg::*;
#(
  parameter int POWERUP_WAIT = 4_000_000,
  parameter int CLEAR_WAIT   = 200_000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         frame_req,
  input  logic [127:0] row1,
  input  logic [127:0] row2,
  output logic [7:0]   byte_data,
  output logic         byte_rs,
  output logic         byte_valid,
  input  logic         byte_ready,
  output logic         init_done,
  output logic         busy,
`ifdef LCD_SEQ_DIFF_EN
  output logic         frame_skipped,
`endif
  output logic         frame_done
);

  localparam logic [31:0] PWR_LAST = 32'(POWERUP_WAIT - 1);
  localparam logic [31:0] CLR_LAST = 32'(CLEAR_WAIT - 1);
  localparam logic [3:0]  IDX_LAST = 4'(LCD_COLS - 1);

  lcd_state_t   state;
  logic [31:0]  wait_cnt;
  logic [3:0]   idx;
  logic         pending;
  logic [127:0] shadow_row1;
  logic [127:0] shadow_row2;
  logic         handshake;
  logic         is_repeat;

`ifdef LCD_SEQ_DIFF_EN
  logic [127:0] last_row1;
  logic [127:0] last_row2;
  logic         last_valid;

  // A start is a repeat only once a frame has actually gone out.
  assign is_repeat = last_valid && (row1 == last_row1) && (row2 == last_row2);
`else
  assign is_repeat = 1'b0;
`endif

  assign handshake = byte_valid && byte_ready;

  // Single sequencer: wait counter is shared between power-up and clear
  // waits, idx doubles as the init-command position and the character
  // position. Output bytes are registered and only change on a handshake,
  // so they stay stable while the driver stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= PWR_WAIT;
      wait_cnt    <= '0;
      idx         <= '0;
      pending     <= 1'b0;
      shadow_row1 <= '0;
      shadow_row2 <= '0;
      byte_data   <= 8'h00;
      byte_rs     <= 1'b0;
      byte_valid  <= 1'b0;
      init_done   <= 1'b0;
      busy        <= 1'b1;
      frame_done  <= 1'b0;
`ifdef LCD_SEQ_DIFF_EN
      frame_skipped <= 1'b0;
      last_row1     <= '0;
      last_row2     <= '0;
      last_valid    <= 1'b0;
`endif
    end else begin
      frame_done <= 1'b0;
`ifdef LCD_SEQ_DIFF_EN
      frame_skipped <= 1'b0;
`endif
      // Requests outside IDLE collapse into one pending start.
      if (frame_req && state != IDLE) pending <= 1'b1;

      case (state)
        PWR_WAIT: begin
          if (wait_cnt == PWR_LAST) begin
            wait_cnt   <= '0;
            idx        <= '0;
            state      <= INIT_CMD;
            byte_valid <= 1'b1;
            byte_data  <= LCD_CMD_FUNCSET;
            byte_rs    <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end

        INIT_CMD: begin
          if (handshake) begin
            if (idx == 4'd3) begin
              state      <= CLR_WAIT;
              byte_valid <= 1'b0;
              wait_cnt   <= '0;
              idx        <= '0;
            end else begin
              idx       <= idx + 4'd1;
              byte_data <= init_cmd(idx[1:0] + 2'd1);
            end
          end
        end

        CLR_WAIT: begin
          if (wait_cnt == CLR_LAST) begin
            wait_cnt  <= '0;
            state     <= IDLE;
            init_done <= 1'b1;
            busy      <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end

        IDLE: begin
          if (frame_req || pending) begin
            pending <= 1'b0;
            if (is_repeat) begin
`ifdef LCD_SEQ_DIFF_EN
              frame_skipped <= 1'b1;
`endif
            end else begin
              shadow_row1 <= row1;
              shadow_row2 <= row2;
              idx         <= '0;
              state       <= ADDR1;
              busy        <= 1'b1;
              byte_valid  <= 1'b1;
              byte_data   <= LCD_ADDR_ROW1;
              byte_rs     <= 1'b0;
            end
          end
        end

        ADDR1: begin
          if (handshake) begin
            state     <= ROW1;
            byte_data <= row_char(shadow_row1, 4'd0);
            byte_rs   <= 1'b1;
          end
        end

        // idx wraps 15 -> 0 naturally when the row ends.
        ROW1: begin
          if (handshake) begin
            idx <= idx + 4'd1;
            if (idx == IDX_LAST) begin
              state     <= ADDR2;
              byte_data <= LCD_ADDR_ROW2;
              byte_rs   <= 1'b0;
            end else begin
              byte_data <= row_char(shadow_row1, idx + 4'd1);
            end
          end
        end

        ADDR2: begin
          if (handshake) begin
            state     <= ROW2;
            byte_data <= row_char(shadow_row2, 4'd0);
            byte_rs   <= 1'b1;
          end
        end

        ROW2: begin
          if (handshake) begin
            idx <= idx + 4'd1;
            if (idx == IDX_LAST) begin
              state      <= IDLE;
              busy       <= 1'b0;
              byte_valid <= 1'b0;
              frame_done <= 1'b1;
`ifdef LCD_SEQ_DIFF_EN
              last_row1  <= shadow_row1;
              last_row2  <= shadow_row2;
              last_valid <= 1'b1;
`endif
            end else begin
              byte_data <= row_char(shadow_row2, idx + 4'd1);
            end
          end
        end

        default: state <= PWR_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_frame_sequencer.sv
// tb_lcd_frame_sequencer: self-checking bench for lcd_frame_sequencer.
// A reference model expands each requested frame into its 34-byte stream
// and compares against bytes captured at handshakes. Build with
// LCD_SEQ_DIFF_EN defined to also exercise duplicate-frame suppression.
module tb_lcd_frame_sequencer;

  localparam int PW = 10;
  localparam int CW = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         frame_req = 1'b0;
  logic [127:0] row1 = '0;
  logic [127:0] row2 = '0;
  logic [7:0]   byte_data;
  logic         byte_rs;
  logic         byte_valid;
  logic         byte_ready = 1'b1;
  logic         init_done;
  logic         busy;
  logic         frame_done;
`ifdef LCD_SEQ_DIFF_EN
  logic         frame_skipped;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int ready_mode = 0;
  int bp_phase = 0;

  // Captured handshakes: {rs, data} and the cycle they transferred in.
  logic [8:0] cap_d[$];
  int         cap_c[$];
  logic [8:0] exp_q[$];
  int         stab_viol = 0;
  int         stall_seen = 0;
  int         skip_cnt = 0;

  lcd_frame_sequencer #(.POWERUP_WAIT(PW), .CLEAR_WAIT(CW)) dut (
    .clk(clk),
    .rst(rst),
    .frame_req(frame_req),
    .row1(row1),
    .row2(row2),
    .byte_data(byte_data),
    .byte_rs(byte_rs),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .init_done(init_done),
    .busy(busy),
`ifdef LCD_SEQ_DIFF_EN
    .frame_skipped(frame_skipped),
`endif
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Driver-side readiness: 0 = always ready, 1 = 1-0-0-1 pattern, 2 = random.
  always @(posedge clk) begin
    #1;
    if (ready_mode == 1) begin
      byte_ready = (bp_phase == 0) || (bp_phase == 3);
      bp_phase = (bp_phase + 1) % 4;
    end else if (ready_mode == 2) begin
      byte_ready = 1'($urandom_range(0, 1));
    end else begin
      byte_ready = 1'b1;
    end
  end

  // Observer at the falling edge: records transfers and stall stability.
  logic       stall_prev = 1'b0;
  logic       rst_prev = 1'b1;
  logic [8:0] held = '0;
  always @(negedge clk) begin
    if (stall_prev && !rst_prev) begin
      if (!(byte_valid === 1'b1 && {byte_rs, byte_data} === held))
        stab_viol = stab_viol + 1;
    end
    if (byte_valid === 1'b1 && byte_ready === 1'b1) begin
      cap_d.push_back({byte_rs, byte_data});
      cap_c.push_back(cyc);
    end
    if (byte_valid === 1'b1 && byte_ready === 1'b0) stall_seen = stall_seen + 1;
`ifdef LCD_SEQ_DIFF_EN
    if (frame_skipped === 1'b1) skip_cnt = skip_cnt + 1;
`endif
    stall_prev = (byte_valid === 1'b1) && (byte_ready === 1'b0);
    held = {byte_rs, byte_data};
    rst_prev = rst;
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Reference model: address, 16 chars leftmost first, address, 16 chars.
  task automatic push_frame(input logic [127:0] r1, input logic [127:0] r2);
    exp_q.push_back({1'b0, 8'h80});
    for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, r1[127-8*i -: 8]});
    exp_q.push_back({1'b0, 8'hC0});
    for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, r2[127-8*i -: 8]});
  endtask

  task automatic compare_stream(input string name);
    checks++;
    if (cap_d.size() !== exp_q.size()) begin
      errors++;
      $display("[TB] FAIL %s_len got=%0d required=%0d", name, cap_d.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < cap_d.size(); i++) begin
      checks++;
      if (cap_d[i] !== exp_q[i]) begin
        errors++;
        $display("[TB] FAIL %s_byte%0d got rs/data=%h required=%h", name, i, cap_d[i], exp_q[i]);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_frame_done(input string name, input int limit, output int c);
    c = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (frame_done === 1'b1) begin
        c = cyc;
        break;
      end
    end
    checks++;
    if (c < 0) begin
      errors++;
      $display("[TB] FAIL %s_timeout got=no frame_done required=frame_done within %0d", name, limit);
    end
  endtask

  task automatic wait_init_done(input int limit, output int c);
    c = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (init_done === 1'b1) begin
        c = cyc;
        break;
      end
    end
    checks++;
    if (c < 0) begin
      errors++;
      $display("[TB] FAIL init_timeout got=init_done low required=high within %0d", limit);
    end
  endtask

  function automatic logic [127:0] rand_row();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check_init_stream(input string name);
    exp_q.delete();
    exp_q.push_back({1'b0, 8'h38});
    exp_q.push_back({1'b0, 8'h0C});
    exp_q.push_back({1'b0, 8'h06});
    exp_q.push_back({1'b0, 8'h01});
    compare_stream(name);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if (byte_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid got=%b required=0", byte_valid); end
    checks++;
    if (byte_data !== 8'h00) begin errors++; $display("[TB] FAIL rst_data got=%h required=00", byte_data); end
    checks++;
    if (byte_rs !== 1'b0) begin errors++; $display("[TB] FAIL rst_rs got=%b required=0", byte_rs); end
    checks++;
    if (init_done !== 1'b0) begin errors++; $display("[TB] FAIL rst_init_done got=%b required=0", init_done); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("[TB] FAIL rst_busy got=%b required=1", busy); end
    checks++;
    if (frame_done !== 1'b0) begin errors++; $display("[TB] FAIL rst_frame_done got=%b required=0", frame_done); end
`ifdef LCD_SEQ_DIFF_EN
    checks++;
    if (frame_skipped !== 1'b0) begin errors++; $display("[TB] FAIL rst_frame_skipped got=%b required=0", frame_skipped); end
`endif
  endtask

  task automatic test_init();
    int rel;
    int dc;
    cap_d.delete();
    cap_c.delete();
    rst = 1'b0;
    rel = cyc;
    wait_init_done(200, dc);
    check_init_stream("init");
    if (cap_c.size() == 4 && dc >= 0) begin
      checks++;
      if (cap_c[0] - rel < PW || cap_c[0] - rel > PW + 2) begin
        errors++;
        $display("[TB] FAIL init_powerup_wait got=%0d required=%0d..%0d", cap_c[0] - rel, PW, PW + 2);
      end
      checks++;
      if (dc - cap_c[3] < CW || dc - cap_c[3] > CW + 1) begin
        errors++;
        $display("[TB] FAIL init_clear_wait got=%0d required=%0d..%0d", dc - cap_c[3], CW, CW + 1);
      end
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_busy got=%b required=0", busy); end
  endtask

  task automatic test_single_frame();
    int t;
    int dc;
    logic [127:0] r1;
    logic [127:0] r2;
    r1 = "Temp: 21 C      ";
    r2 = "Humi: 40%       ";
    cap_d.delete();
    cap_c.delete();
    exp_q.delete();
    push_frame(r1, r2);
    tick();
    t = cyc;
    row1 = r1;
    row2 = r2;
    frame_req = 1'b1;
    tick();
    frame_req = 1'b0;
    repeat (4) tick();
    row1 = rand_row();
    row2 = rand_row();
    wait_frame_done("single", 100, dc);
    checks++;
    if (dc !== t + 35) begin errors++; $display("[TB] FAIL single_done_cycle got=%0d required=%0d", dc - t, 35); end
    if (cap_c.size() == 34) begin
      checks++;
      if (cap_c[0] !== t + 1) begin errors++; $display("[TB] FAIL single_first_byte got=%0d required=1", cap_c[0] - t); end
      checks++;
      if (cap_c[33] !== t + 34) begin errors++; $display("[TB] FAIL single_last_byte got=%0d required=34", cap_c[33] - t); end
    end
    compare_stream("single");
    tick();
  endtask

  task automatic test_backpressure();
    int dc;
    logic [127:0] r1;
    logic [127:0] r2;
    r1 = rand_row();
    r2 = rand_row();
    ready_mode = 1;
    bp_phase = 0;
    stab_viol = 0;
    stall_seen = 0;
    cap_d.delete();
    cap_c.delete();
    exp_q.delete();
    push_frame(r1, r2);
    tick();
    row1 = r1;
    row2 = r2;
    frame_req = 1'b1;
    tick();
    frame_req = 1'b0;
    wait_frame_done("bp", 300, dc);
    compare_stream("bp");
    checks++;
    if (stab_viol !== 0) begin errors++; $display("[TB] FAIL bp_hold_stable got=%0d changes required=0", stab_viol); end
    checks++;
    if (stall_seen == 0) begin errors++; $display("[TB] FAIL bp_stalls got=%0d required=nonzero", stall_seen); end
    ready_mode = 0;
    tick();
  endtask

  task automatic test_pending_merge();
    int t;
    int dc;
    int dc2;
    logic [127:0] a1;
    logic [127:0] a2;
    logic [127:0] c1;
    logic [127:0] c2;
    a1 = rand_row();
    a2 = rand_row();
    c1 = rand_row();
    c2 = rand_row();
    cap_d.delete();
    cap_c.delete();
    exp_q.delete();
    push_frame(a1, a2);
    push_frame(c1, c2);
    tick();
    t = cyc;
    row1 = a1;
    row2 = a2;
    frame_req = 1'b1;
    for (int k = 1; k <= 34; k++) begin
      tick();
      frame_req = 1'b0;
      if (k == 3 || k == 10 || k == 20) begin
        frame_req = 1'b1;
        row1 = rand_row();
        row2 = rand_row();
      end
      if (k == 30) begin
        row1 = c1;
        row2 = c2;
      end
    end
    wait_frame_done("merge1", 10, dc);
    checks++;
    if (dc !== t + 35) begin errors++; $display("[TB] FAIL merge_done1 got=%0d required=35", dc - t); end
    wait_frame_done("merge2", 60, dc2);
    checks++;
    if (dc2 !== t + 70) begin errors++; $display("[TB] FAIL merge_done2 got=%0d required=70", dc2 - t); end
    if (cap_c.size() > 34) begin
      checks++;
      if (cap_c[34] !== t + 36) begin errors++; $display("[TB] FAIL merge_restart got=%0d required=36", cap_c[34] - t); end
    end
    repeat (40) tick();
    compare_stream("merge");
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL merge_idle got busy=%b required=0", busy); end
  endtask

  task automatic test_back_to_back();
    int dc;
    logic [127:0] a1;
    logic [127:0] a2;
    logic [127:0] b1;
    logic [127:0] b2;
    a1 = rand_row();
    a2 = rand_row();
    b1 = rand_row();
    b2 = rand_row();
    ready_mode = 2;
    stab_viol = 0;
    cap_d.delete();
    cap_c.delete();
    exp_q.delete();
    push_frame(a1, a2);
    push_frame(b1, b2);
    tick();
    row1 = a1;
    row2 = a2;
    frame_req = 1'b1;
    tick();
    frame_req = 1'b0;
    repeat (4) tick();
    row1 = b1;
    row2 = b2;
    frame_req = 1'b1;
    tick();
    frame_req = 1'b0;
    wait_frame_done("b2b1", 400, dc);
    wait_frame_done("b2b2", 400, dc);
    compare_stream("b2b");
    checks++;
    if (stab_viol !== 0) begin errors++; $display("[TB] FAIL b2b_hold_stable got=%0d changes required=0", stab_viol); end
    ready_mode = 0;
    repeat (2) tick();
  endtask

  task automatic test_reset_midframe();
    int dc;
    cap_d.delete();
    cap_c.delete();
    tick();
    row1 = rand_row();
    row2 = rand_row();
    frame_req = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      frame_req = (k == 5);
    end
    rst = 1'b1;
    frame_req = 1'b1;
    tick();
    frame_req = 1'b0;
    checks++;
    if (byte_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_valid got=%b required=0", byte_valid); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("[TB] FAIL midrst_busy got=%b required=1", busy); end
    checks++;
    if (init_done !== 1'b0) begin errors++; $display("[TB] FAIL midrst_init_done got=%b required=0", init_done); end
    tick();
    cap_d.delete();
    cap_c.delete();
    rst = 1'b0;
    wait_init_done(200, dc);
    repeat (40) tick();
    check_init_stream("midrst_reinit");
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_idle got busy=%b required=0", busy); end
  endtask

`ifdef LCD_SEQ_DIFF_EN
  task automatic test_diff();
    int dc;
    int sk;
    logic [127:0] x1;
    logic [127:0] x2;
    logic [127:0] y2;
    x1 = rand_row();
    x2 = rand_row();
    y2 = rand_row();
    tick();
    row1 = x1;
    row2 = x2;
    frame_req = 1'b1;
    tick();
    frame_req = 1'b0;
    wait_frame_done("diff_first", 100, dc);
    tick();
    cap_d.delete();
    cap_c.delete();
    sk = skip_cnt;
    frame_req = 1'b1;
    tick();
    frame_req = 1'b0;
    repeat (40) tick();
    checks++;
    if (cap_d.size() !== 0) begin errors++; $display("[TB] FAIL diff_same_bytes got=%0d required=0", cap_d.size()); end
    checks++;
    if (skip_cnt - sk !== 1) begin errors++; $display("[TB] FAIL diff_skip_pulses got=%0d required=1", skip_cnt - sk); end
    exp_q.delete();
    push_frame(x1, y2);
    row2 = y2;
    frame_req = 1'b1;
    tick();
    frame_req = 1'b0;
    wait_frame_done("diff_changed", 100, dc);
    compare_stream("diff_changed");
  endtask
`endif

  initial begin
    $display("[TB] lcd_frame_sequencer bench start");
    test_reset();
    test_init();
    test_single_frame();
    test_backpressure();
    test_pending_merge();
    test_back_to_back();
`ifdef LCD_SEQ_DIFF_EN
    test_diff();
`endif
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
